// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator over a raster 8-bit pixel stream.
// Optional WINDOW_LAST_EN adds o_last marking the final window of a frame.
module window_gen_3x3 #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_ready,
  input  logic        i_ready,
  output logic [71:0] o_data,
`ifdef WINDOW_LAST_EN
  output logic        o_last,
`endif
  output logic        o_valid
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic [7:0] lb_a [IMG_WIDTH];
  logic [7:0] lb_b [IMG_WIDTH];

  logic [2:0][2:0][7:0] win;

  logic       accept;
  logic       xfer;
  logic       col_end;
  logic       row_end;
  logic       full_win;
  logic [7:0] up1;
  logic [7:0] up2;

  assign o_ready  = !o_valid || i_ready;
  assign accept   = i_valid && o_ready;
  assign xfer     = o_valid && i_ready;
  assign col_end  = (col == COL_LAST);
  assign row_end  = (row == ROW_LAST);
  assign full_win = (row >= ROW_TWO) && (col >= COL_TWO);
  assign up1      = lb_a[col];
  assign up2      = lb_b[col];
  assign o_data   = win;

  // Line RAMs carry no reset; row gating keeps stale lines hidden.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      lb_b[col] <= up1;
      lb_a[col] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Row 0 is the oldest line; column 2 is the newest pixel.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      win <= '0;
    end else if (accept) begin
      win[0] <= {up2,    win[0][2], win[0][1]};
      win[1] <= {up1,    win[1][2], win[1][1]};
      win[2] <= {i_data, win[2][2], win[2][1]};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid <= 1'b0;
    end else if (accept) begin
      o_valid <= full_win;
    end else if (xfer) begin
      o_valid <= 1'b0;
    end
  end

`ifdef WINDOW_LAST_EN
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_last <= 1'b0;
    end else if (accept) begin
      o_last <= row_end && col_end;
    end else if (xfer) begin
      o_last <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3 on a 5x4 image.
// Covers first/last windows, stalls, back-to-back frames and mid-frame reset.
module tb_window_gen_3x3;

  localparam int W = 5;
  localparam int H = 4;
  localparam int NW = (W - 2) * (H - 2);

  logic        i_clk;
  logic        i_reset_n;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        o_ready;
  logic        i_ready;
  logic [71:0] o_data;
  logic        o_valid;
  logic        lastv;

  int total;
  int bad;

  logic [71:0] got_q[$];
  logic        last_q[$];

  window_gen_3x3 #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .o_ready  (o_ready),
    .i_ready  (i_ready),
    .o_data   (o_data),
`ifdef WINDOW_LAST_EN
    .o_last   (lastv),
`endif
    .o_valid  (o_valid)
  );

`ifndef WINDOW_LAST_EN
  assign lastv = 1'b0;
`endif

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [71:0] got,
                     input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int f, input int y, input int x);
    pix = 8'((f * 8'h80) + 16 * y + x);
  endfunction

  function automatic logic [71:0] exp_win(input int f, input int wi);
    int y;
    int x;
    logic [71:0] w;
    y = 2 + wi / (W - 2);
    x = 2 + wi % (W - 2);
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[8*(3*r+c) +: 8] = pix(f, y - 2 + r, x - 2 + c);
    return w;
  endfunction

  function automatic logic [7:0] pix_n(input int n);
    int f;
    int rem;
    f = n / (W * H);
    rem = n % (W * H);
    return pix(f, rem / W, rem % W);
  endfunction

  // mode 0: ready high, 1: ready toggles, 2: one 4-cycle stall
  task automatic stream(input int nfr, input int mode, input int stop_at);
    int n;
    int lim;
    int cyc;
    int scnt;
    bit did;
    bit in_stall;
    bit acc;
    logic [71:0] held;
    n = 0;
    cyc = 0;
    scnt = 0;
    did = 0;
    in_stall = 0;
    held = '0;
    lim = (stop_at > 0) ? stop_at : nfr * W * H;
    got_q.delete();
    last_q.delete();
    i_valid = 1'b1;
    i_data = pix_n(0);
    i_ready = 1'b1;
    while ((n < lim || (stop_at == 0 && o_valid)) && cyc < 2000) begin
      @(negedge i_clk);
      if (o_valid && !i_ready) begin
        chk("stall_ready", {71'd0, o_ready}, 72'd0);
        if (in_stall) chk("stall_data", o_data, held);
        else held = o_data;
        in_stall = 1;
      end else begin
        in_stall = 0;
      end
      if (o_valid && i_ready) begin
        got_q.push_back(o_data);
        last_q.push_back(lastv);
      end
      acc = i_valid && o_ready;
      @(posedge i_clk);
      #1;
      cyc++;
      if (acc) n++;
      i_valid = (n < lim);
      i_data = pix_n(n);
      case (mode)
        1: i_ready = ~i_ready;
        2: begin
          if (!did && o_valid) begin
            did = 1;
            scnt = 4;
            i_ready = 1'b0;
          end else if (scnt > 0) begin
            scnt--;
            i_ready = (scnt == 0);
          end
        end
        default: i_ready = 1'b1;
      endcase
    end
    i_valid = 1'b0;
    if (cyc >= 2000) chk("timeout", 72'd1, 72'd0);
  endtask

  task automatic chk_seq(input string tag, input int nfr);
    chk({tag, "_count"}, 72'(got_q.size()), 72'(nfr * NW));
    for (int i = 0; i < got_q.size() && i < nfr * NW; i++)
      chk(tag, got_q[i], exp_win(i / NW, i % NW));
  endtask

  task automatic chk_last(input string tag);
`ifdef WINDOW_LAST_EN
    for (int i = 0; i < last_q.size(); i++)
      chk(tag, {71'd0, last_q[i]}, {71'd0, i == NW - 1});
`else
    chk(tag, 72'(last_q.size()), 72'(got_q.size()));
`endif
  endtask

  initial begin
    total = 0;
    bad = 0;
    i_reset_n = 1'b0;
    i_valid = 1'b0;
    i_data = '0;
    i_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", {71'd0, o_valid}, 72'd0);
    chk("rst_data", o_data, 72'd0);
    chk("rst_ready", {71'd0, o_ready}, 72'd1);
    chk("rst_last", {71'd0, lastv}, 72'd0);
    i_reset_n = 1'b1;

    stream(1, 0, 0);
    chk_seq("plain", 1);
    if (got_q.size() == NW) begin
      chk("first_win", got_q[0], 72'h22_21_20_12_11_10_02_01_00);
      chk("second_win", got_q[1], 72'h23_22_21_13_12_11_03_02_01);
      chk("last_win", got_q[5], 72'h34_33_32_24_23_22_14_13_12);
    end else begin
      chk("plain_size", 72'(got_q.size()), 72'(NW));
    end
    chk_last("plain_last");

    stream(1, 2, 0);
    chk_seq("stall", 1);

    stream(2, 0, 0);
    chk_seq("b2b", 2);
    if (got_q.size() == 2 * NW)
      chk("f2_first", got_q[NW], 72'hA2_A1_A0_92_91_90_82_81_80);
    else
      chk("b2b_size", 72'(got_q.size()), 72'(2 * NW));

    stream(1, 1, 0);
    chk_seq("toggle", 1);
    chk_last("toggle_last");

    stream(1, 0, 2 * W + 3 + 1);
    chk("pre_rst_valid", {71'd0, o_valid}, 72'd1);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {71'd0, o_valid}, 72'd0);
    chk("mid_rst_ready", {71'd0, o_ready}, 72'd1);
    chk("mid_rst_data", o_data, 72'd0);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    stream(1, 0, 0);
    chk_seq("after_rst", 1);
    if (got_q.size() > 0)
      chk("after_rst_first", got_q[0], 72'h22_21_20_12_11_10_02_01_00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
